// File: rtl/video_timing_pkg.sv
// Shared constants, helpers and types for the 15 kHz raster generator.
// Holds default timing, line/frame total and sync window helpers, rgb_t unpacking.
package video_timing_pkg;

    localparam int DEF_COLOR_DEPTH = 6;
    localparam int DEF_CE_DIV      = 4;
    localparam int DEF_H_ACTIVE    = 320;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 32;
    localparam int DEF_H_BP        = 40;
    localparam int DEF_V_ACTIVE    = 240;
    localparam int DEF_V_FP        = 3;
    localparam int DEF_V_SYNC      = 3;
    localparam int DEF_V_BP        = 16;
    localparam int DEF_FIFO_DEPTH  = 16;
    localparam int MAX_DEPTH       = 6;

    typedef struct packed {
        logic [MAX_DEPTH-1:0] r;
        logic [MAX_DEPTH-1:0] g;
        logic [MAX_DEPTH-1:0] b;
    } rgb_t;

    function automatic int line_total(input int act, input int fp,
                                      input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // First count with sync asserted.
    function automatic int sync_start(input int act, input int fp);
        return act + fp;
    endfunction

    // First count after sync has been released.
    function automatic int sync_end(input int act, input int fp, input int sync);
        return act + fp + sync;
    endfunction

    localparam int H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP,
                                        DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP,
                                        DEF_V_SYNC, DEF_V_BP);

    // Splits a packed {R,G,B} word of `depth` bits per channel into
    // right-aligned channel fields.
    function automatic rgb_t rgb_unpack(input logic [3*MAX_DEPTH-1:0] pix,
                                        input int depth);
        logic [MAX_DEPTH-1:0] m;
        rgb_t v;
        m   = MAX_DEPTH'((1 << depth) - 1);
        v.r = MAX_DEPTH'(pix >> (2 * depth)) & m;
        v.g = MAX_DEPTH'(pix >> depth) & m;
        v.b = pix[MAX_DEPTH-1:0] & m;
        return v;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel valid/ready handshake between the core (master) and the raster generator (slave).
// Signals: pix_data {R,G,B}, pix_valid, pix_ready.
interface video_timing_gen_if
    import video_timing_pkg::*;
#(
    parameter int W = 3 * DEF_COLOR_DEPTH
);
    logic [W-1:0] pix_data;
    logic         pix_valid;
    logic         pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/video_timing_gen_pixel_fifo.sv
// Single-clock first-word-fall-through pixel FIFO.
// Ports: i_clk, i_rst (sync, high), i_wr/i_wdata, i_rd, o_rdata, o_full, o_empty.
module pixel_fifo
    import video_timing_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int W     = 3 * DEF_COLOR_DEPTH
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_rd,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;
    logic         w_wen;
    logic         w_ren;

    // Extra pointer MSB separates full from empty when the indices match.
    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_rdata = r_mem[r_rp[AW-1:0]];
    assign w_wen   = i_wr & ~o_full;
    assign w_ren   = i_rd & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wen) begin
            r_mem[r_wp[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wen) r_wp <= r_wp + 1'b1;
            if (w_ren) r_rp <= r_rp + 1'b1;
        end
    end
endmodule

// File: rtl/video_timing_gen.sv
// 15 kHz raster generator draining a pixel FIFO into R/G/B/HSync/VSync.
// Ports: clk_sys, reset (sync, high), pix (slave handshake), R/G/B, HSync,
// VSync, de, frame_start, underflow_cnt. Macro VIDEO_TIMING_TEST_PATTERN_EN
// adds input test_pattern which shows 8 colour bars instead of FIFO data.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
    parameter int CE_DIV      = DEF_CE_DIV,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic                   clk_sys,
    input  logic                   reset,
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    input  logic                   test_pattern,
`endif
    video_timing_gen_if.slave      pix,
    output logic [COLOR_DEPTH-1:0] R,
    output logic [COLOR_DEPTH-1:0] G,
    output logic [COLOR_DEPTH-1:0] B,
    output logic                   HSync,
    output logic                   VSync,
    output logic                   de,
    output logic                   frame_start,
    output logic [15:0]            underflow_cnt
);
    localparam int HT = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VT = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam int DW = $clog2(CE_DIV);
    localparam int PW = 3 * COLOR_DEPTH;

    localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(CE_DIV - 2);
    localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_ON    = HW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [HW-1:0] HS_OFF   = HW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_ON    = VW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [VW-1:0] VS_OFF   = VW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic [DW-1:0]          r_div;
    logic [HW-1:0]          r_hcnt;
    logic [VW-1:0]          r_vcnt;
    logic [COLOR_DEPTH-1:0] r_r;
    logic [COLOR_DEPTH-1:0] r_g;
    logic [COLOR_DEPTH-1:0] r_b;
    logic                   r_de;
    logic                   r_hs;
    logic                   r_vs;
    logic                   r_fs;
    logic [15:0]            r_uf;

    logic                   w_ce;
    logic                   w_active;
    logic                   w_hs_on;
    logic                   w_vs_on;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_starve;
    logic [PW-1:0]          w_fifo_data;
    rgb_t                   w_pix;
    logic [COLOR_DEPTH-1:0] w_r_nxt;
    logic [COLOR_DEPTH-1:0] w_g_nxt;
    logic [COLOR_DEPTH-1:0] w_b_nxt;

    assign w_ce     = (r_div == DIV_LAST);
    assign w_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    assign w_hs_on  = (r_hcnt >= HS_ON) && (r_hcnt < HS_OFF);
    assign w_vs_on  = (r_vcnt >= VS_ON) && (r_vcnt < VS_OFF);

    // Ready is held low for the whole reset so no word is taken that
    // the FIFO reset would then discard.
    assign pix.pix_ready = ~w_full & ~reset;
    assign w_push        = pix.pix_valid & pix.pix_ready;

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);

    logic [2:0] w_bar;

    assign w_bar    = 3'(r_hcnt / BAR_W);
    assign w_pop    = w_ce & w_active & ~w_empty & ~test_pattern;
    assign w_starve = w_ce & w_active & w_empty & ~test_pattern;
`else
    assign w_pop    = w_ce & w_active & ~w_empty;
    assign w_starve = w_ce & w_active & w_empty;
`endif

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PW)
    ) u_fifo (
        .i_clk   (clk_sys),
        .i_rst   (reset),
        .i_wr    (w_push),
        .i_wdata (pix.pix_data),
        .i_rd    (w_pop),
        .o_rdata (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pix = rgb_unpack((3 * MAX_DEPTH)'(w_fifo_data), COLOR_DEPTH);

    // Starved active pixels and blanking both stay black.
    always_comb begin
        w_r_nxt = '0;
        w_g_nxt = '0;
        w_b_nxt = '0;
        if (w_active && !w_empty) begin
            w_r_nxt = w_pix.r[COLOR_DEPTH-1:0];
            w_g_nxt = w_pix.g[COLOR_DEPTH-1:0];
            w_b_nxt = w_pix.b[COLOR_DEPTH-1:0];
        end
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
        if (w_active && test_pattern) begin
            w_r_nxt = {COLOR_DEPTH{w_bar[2]}};
            w_g_nxt = {COLOR_DEPTH{w_bar[1]}};
            w_b_nxt = {COLOR_DEPTH{w_bar[0]}};
        end
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_div  <= '0;
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_r    <= '0;
            r_g    <= '0;
            r_b    <= '0;
            r_de   <= 1'b0;
            r_hs   <= ~SYNC_POL;
            r_vs   <= ~SYNC_POL;
            r_fs   <= 1'b0;
            r_uf   <= '0;
        end else begin
            r_div <= w_ce ? '0 : r_div + 1'b1;
            // Raised one clk early so the pulse coincides with the ce
            // that presents raster position (0,0).
            r_fs  <= (r_div == DIV_PRE) && (r_hcnt == '0) && (r_vcnt == '0);
            if (w_ce) begin
                if (r_hcnt == H_LAST) begin
                    r_hcnt <= '0;
                    r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
                end else begin
                    r_hcnt <= r_hcnt + 1'b1;
                end
                r_r  <= w_r_nxt;
                r_g  <= w_g_nxt;
                r_b  <= w_b_nxt;
                r_de <= w_active;
                r_hs <= w_hs_on ? SYNC_POL : ~SYNC_POL;
                r_vs <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            end
            if (w_starve && r_uf != 16'hFFFF) begin
                r_uf <= r_uf + 16'd1;
            end
        end
    end

    assign R             = r_r;
    assign G             = r_g;
    assign B             = r_b;
    assign de            = r_de;
    assign HSync         = r_hs;
    assign VSync         = r_vs;
    assign frame_start   = r_fs;
    assign underflow_cnt = r_uf;
endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized scoreboard bench for video_timing_gen on a shrunken raster.
// Model derives raster position from clk index; monitor compares every clk.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int CD  = 6;
    localparam int CE  = 4;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HSW = 4;
    localparam int HBP = 3;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam int FD  = 4;
    localparam bit POL = 1'b0;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int PW  = 3 * CD;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    video_timing_gen_if #(.W(PW)) pix();

    logic [CD-1:0] R;
    logic [CD-1:0] G;
    logic [CD-1:0] B;
    logic          HSync;
    logic          VSync;
    logic          de;
    logic          frame_start;
    logic [15:0]   underflow_cnt;
    bit            tp_now = 1'b0;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    logic          test_pattern = 1'b0;
`endif

    video_timing_gen #(
        .COLOR_DEPTH (CD),
        .CE_DIV      (CE),
        .H_ACTIVE    (HA),
        .H_FP        (HFP),
        .H_SYNC      (HSW),
        .H_BP        (HBP),
        .V_ACTIVE    (VA),
        .V_FP        (VFP),
        .V_SYNC      (VSW),
        .V_BP        (VBP),
        .FIFO_DEPTH  (FD),
        .SYNC_POL    (POL)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
        .test_pattern  (test_pattern),
`endif
        .pix           (pix),
        .R             (R),
        .G             (G),
        .B             (B),
        .HSync         (HSync),
        .VSync         (VSync),
        .de            (de),
        .frame_start   (frame_start),
        .underflow_cnt (underflow_cnt)
    );

    typedef struct {
        logic [PW-1:0] rgb;
        bit            de;
        bit            hs;
        bit            vs;
        bit            fs;
        bit            rdy;
        int            uf;
    } exp_t;

    exp_t          exp_q[$];
    logic [PW-1:0] mq[$];
    exp_t          cur;
    int            k;
    int            uf;
    int            ramp;
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string n, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s t=%0t got=%0h want=%0h", n, $time, act, want);
        end
    endtask

    function automatic logic [PW-1:0] bar(input int h);
        logic [2:0] b;
        b = 3'(h / (HA / 8));
        return {{CD{b[2]}}, {CD{b[1]}}, {CD{b[0]}}};
    endfunction

    // One clk: advance the model over the edge with the applied inputs,
    // queue what the outputs must show after it, then apply new inputs.
    task automatic step(input int pv, input bit rn, input bit tn, input bit rm);
        int p, h, v;
        bit ce, act, push;
        bit nv;
        logic [PW-1:0] nd;
        exp_t e;
        @(posedge clk_sys);
        if (reset) begin
            mq.delete();
            uf      = 0;
            k       = 0;
            cur.rgb = '0;
            cur.de  = 1'b0;
            cur.hs  = ~POL;
            cur.vs  = ~POL;
        end else begin
            ce   = (k % CE) == CE - 1;
            p    = k / CE;
            h    = p % HT;
            v    = (p / HT) % VT;
            act  = (h < HA) && (v < VA);
            push = pix.pix_valid && (mq.size() < FD);
            if (ce) begin
                cur.de  = act;
                cur.hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? POL : ~POL;
                cur.vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? POL : ~POL;
                cur.rgb = '0;
                if (act) begin
                    if (tp_now)
                        cur.rgb = bar(h);
                    else if (mq.size() > 0)
                        cur.rgb = mq.pop_front();
                    else if (uf < 65535)
                        uf++;
                end
            end
            if (push) begin
                mq.push_back(pix.pix_data);
                if (rm) ramp++;
            end
            k++;
        end
        nv    = ($urandom_range(99) < pv);
        nd    = rm ? PW'(ramp) : PW'($urandom);
        e     = cur;
        e.fs  = !reset && ((k % CE) == CE - 1) && (((k / CE) % (HT * VT)) == 0);
        e.rdy = !rn && (mq.size() < FD);
        e.uf  = uf;
        exp_q.push_back(e);
        #1;
        reset         = rn;
        pix.pix_valid = nv;
        pix.pix_data  = nd;
        tp_now        = tn;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
        test_pattern  = tn;
`endif
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rgb", {R, G, B}, e.rgb);
                chk("de", de, e.de);
                chk("hsync", HSync, e.hs);
                chk("vsync", VSync, e.vs);
                chk("frame_start", frame_start, e.fs);
                chk("pix_ready", pix.pix_ready, e.rdy);
                chk("underflow_cnt", underflow_cnt, e.uf);
            end
        end
    end

    initial begin
        pix.pix_valid = 1'b0;
        pix.pix_data  = '0;
        ramp          = 0;
        cur.rgb       = '0;
        step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        repeat (1100) step(0, 1'b0, 1'b0, 1'b0);
        repeat (2000) step(100, 1'b0, 1'b0, 1'b1);
        repeat (2000) step(50, 1'b0, 1'b0, 1'b0);
        repeat (1500) step(15, 1'b0, 1'b0, 1'b0);
        repeat (437) step(80, 1'b0, 1'b0, 1'b0);
        step(80, 1'b1, 1'b0, 1'b0);
        step(80, 1'b1, 1'b0, 1'b0);
        step(80, 1'b0, 1'b0, 1'b0);
        repeat (2500) step(90, 1'b0, 1'b0, 1'b0);
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
        repeat (1200) step(60, 1'b0, 1'b1, 1'b0);
`endif
        repeat (3) @(negedge clk_sys);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
